// File: rtl/i2s_pkg.sv
// Shared I2S frame constants and lock-state encoding, common to the slave receiver
// and the master clock generator.
package i2s_pkg;

  localparam int unsigned FRAME_SLOTS = 64;
  localparam int unsigned HALF_SLOTS  = 32;

  typedef enum logic [1:0] {
    HUNT,
    ALIGN,
    LOCK
  } lock_state_e;

  function automatic logic in_window(logic [5:0] posn, logic [5:0] lo, logic [5:0] hi);
    return (posn >= lo) && (posn <= hi);
  endfunction

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, plus a one-cycle rising-edge pulse
// on the synchronised level.
module i2s_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic ck_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge ck_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;

endmodule

// File: rtl/i2s_slave_rx.sv
// I2S slave receiver: recovers the 64-slot frame position from ws, captures left/right
// samples with the one-bit I2S delay and tracks frame lock.
module i2s_slave_rx
  import i2s_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             sck,
  input  logic             ws,
  input  logic             sd,
  output logic [WIDTH-1:0] left,
  output logic [WIDTH-1:0] right,
  output logic             valid,
  output logic [5:0]       frame_posn,
  output logic             locked,
  output logic             err
);

  localparam logic [5:0] LastSlot   = 6'(FRAME_SLOTS - 1);
  localparam logic [5:0] MidSlot    = 6'(HALF_SLOTS - 1);
  localparam logic [5:0] LeftLast   = 6'(WIDTH);
  localparam logic [5:0] RightFirst = 6'(HALF_SLOTS + 1);
  localparam logic [5:0] RightLast  = 6'(HALF_SLOTS + WIDTH);

  logic sck_lvl, sck_rise;

  i2s_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sck_sync (
    .ck_i   (ck),
    .rst_i  (rst),
    .d_i    (sck),
    .level_o(sck_lvl),
    .rise_o (sck_rise)
  );

  logic [SYNC_STAGES-1:0] ws_sync_q, ws_sync_d, sd_sync_q, sd_sync_d;
  logic                   ws_d_q, ws_d_d;
  logic [5:0]             posn_q, posn_d;
  logic [WIDTH-1:0]       left_sr_q, left_sr_d, right_sr_q, right_sr_d;
  logic [WIDTH-1:0]       left_q, left_d, right_q, right_d;
  logic                   valid_q, valid_d, err_q, err_d;
  lock_state_e            state_q, state_d;

  logic       ws_s, sd_s, tick, ws_fall, ws_rise, bad_edge;
  logic [5:0] posn_next;

  always_comb begin
    ws_sync_d = {ws_sync_q[SYNC_STAGES-2:0], ws};
    sd_sync_d = {sd_sync_q[SYNC_STAGES-2:0], sd};
  end

  assign ws_s      = ws_sync_q[SYNC_STAGES-1];
  assign sd_s      = sd_sync_q[SYNC_STAGES-1];
  assign tick      = sck_rise & sck_lvl;
  assign ws_fall   = tick & ws_d_q & ~ws_s;
  assign ws_rise   = tick & ~ws_d_q & ws_s;
  assign posn_next = ws_fall ? 6'd0 : posn_q + 6'd1;
  assign bad_edge  = (ws_fall && (posn_q != LastSlot)) || (ws_rise && (posn_q != MidSlot));

  // Capture windows use the post-tick position: slot 0 / 32 carry the previous LSB.
  always_comb begin
    ws_d_d     = ws_d_q;
    posn_d     = posn_q;
    left_sr_d  = left_sr_q;
    right_sr_d = right_sr_q;
    left_d     = left_q;
    right_d    = right_q;
    valid_d    = 1'b0;
    if (tick) begin
      ws_d_d = ws_s;
      posn_d = posn_next;
      if (in_window(posn_next, 6'd1, LeftLast)) begin
        left_sr_d = {left_sr_q[WIDTH-2:0], sd_s};
      end
      if (in_window(posn_next, RightFirst, RightLast)) begin
        right_sr_d = {right_sr_q[WIDTH-2:0], sd_s};
      end
      if (posn_next == RightLast) begin
        left_d  = left_sr_d;
        right_d = right_sr_d;
        valid_d = (state_q == LOCK);
      end
    end
  end

  // No frame reference exists in HUNT, so edges there are not reported as errors.
  always_comb begin
    state_d = state_q;
    err_d   = bad_edge && (state_q != HUNT);
    unique case (state_q)
      HUNT:    if (ws_fall) state_d = ALIGN;
      ALIGN:   if (!bad_edge && ws_fall) state_d = LOCK;
      LOCK:    if (bad_edge) state_d = ALIGN;
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      ws_sync_q  <= '0;
      sd_sync_q  <= '0;
      ws_d_q     <= 1'b1;
      posn_q     <= '0;
      left_sr_q  <= '0;
      right_sr_q <= '0;
      left_q     <= '0;
      right_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      state_q    <= HUNT;
    end else begin
      ws_sync_q  <= ws_sync_d;
      sd_sync_q  <= sd_sync_d;
      ws_d_q     <= ws_d_d;
      posn_q     <= posn_d;
      left_sr_q  <= left_sr_d;
      right_sr_q <= right_sr_d;
      left_q     <= left_d;
      right_q    <= right_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      state_q    <= state_d;
    end
  end

  assign left       = left_q;
  assign right      = right_q;
  assign valid      = valid_q;
  assign frame_posn = posn_q;
  assign locked     = (state_q == LOCK);
  assign err        = err_q;

endmodule
